// File: rtl/pattern_sequencer_if.sv
// Bundle of the game-round controller's player/display signals.
// The master side drives start/rnd/btn and observes the status outputs.
// The slave side is the pattern_sequencer itself.
interface pattern_sequencer_if;
  logic       start;
  logic [3:0] rnd;
  logic [3:0] btn;
  logic [3:0] led;
  logic       busy;
  logic [6:0] level;
  logic       win;
  logic       lose;

  modport master (
    output start, rnd, btn,
    input  led, busy, level, win, lose
  );

  modport slave (
    input  start, rnd, btn,
    output led, busy, level, win, lose
  );
endinterface

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: memory-game round controller.
// Each round appends one LFSR symbol to a stored pattern, plays the pattern back
// on one-hot LEDs, then checks the player's presses. The game ends in WIN when
// the pattern reaches MAX_LEN, or in LOSE on a wrong press.
// Optional build macro PATTERN_TIMEOUT_EN: when defined, TIMEOUT_CYC idle cycles
// in WAIT_INPUT with no press also end the game in LOSE.
// All outputs are registered; reset is asynchronous and active-low.
module pattern_sequencer #(
  parameter int MAX_LEN     = 16,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  pattern_sequencer_if.slave  bus
);

  localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_MAX0 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYC) ? CNT_MAX0 : TIMEOUT_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_WAIT_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       level_q, level_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;

  // Symbol storage; never cleared, each round rewrites the slot it extends.
  logic [1:0]       sym_mem [MAX_LEN];
  logic             mem_we;
  logic [IDX_W-1:0] wr_idx;

  logic [6:0]       level_m1;
  logic [6:0]       ptr_ext;
  logic             ptr_is_last;
  logic [3:0]       exp_onehot;
  logic [1:0]       sym_next;

  // Upper LFSR bits carry no symbol information.
  logic             unused_rnd_hi;
  assign unused_rnd_hi = ^bus.rnd[3:2];

  assign level_m1    = level_q - 7'd1;
  assign wr_idx      = IDX_W'(level_m1);
  assign ptr_ext     = 7'(ptr_q);
  assign ptr_is_last = (ptr_ext == level_m1);
  assign exp_onehot  = 4'b0001 << sym_mem[ptr_q];

  // Next-state, pointer, counter and level computation.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          level_d = 7'd1;
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        mem_we  = 1'b1;
        ptr_d   = '0;
        cnt_d   = '0;
        state_d = S_SHOW_ON;
      end

      S_SHOW_ON: begin
        if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SHOW_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHOW_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (ptr_is_last) begin
            ptr_d   = '0;
            state_d = S_WAIT_INPUT;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_INPUT: begin
        if (bus.btn != 4'b0000) begin
          // Any press restarts the idle count; multi-bit presses never match.
          cnt_d = '0;
          if (bus.btn != exp_onehot) begin
            state_d = S_LOSE;
          end else if (!ptr_is_last) begin
            ptr_d = ptr_q + 1'b1;
          end else if (level_q == 7'(MAX_LEN)) begin
            state_d = S_WIN;
          end else begin
            level_d = level_q + 7'd1;
            state_d = S_CAPTURE;
          end
        end else begin
`ifdef PATTERN_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            cnt_d   = '0;
            state_d = S_LOSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end

      S_WIN, S_LOSE: begin
        if (bus.start) begin
          level_d = 7'd1;
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end

      default: begin
        state_d = S_IDLE;
        level_d = '0;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs derived from the upcoming state so they are valid right after the edge.
  always_comb begin
    // The symbol captured this cycle is not in the buffer yet, so forward it.
    if ((state_q == S_CAPTURE) && (ptr_d == wr_idx)) begin
      sym_next = bus.rnd[1:0];
    end else begin
      sym_next = sym_mem[ptr_d];
    end

    case (state_d)
      S_SHOW_ON: led_d = 4'b0001 << sym_next;
      S_WIN:     led_d = 4'b1111;
      default:   led_d = 4'b0000;
    endcase

    busy_d = (state_d == S_CAPTURE) || (state_d == S_SHOW_ON) || (state_d == S_SHOW_GAP);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Symbol buffer write, one slot per round.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      sym_mem[wr_idx] <= bus.rnd[1:0];
    end
  end

  assign bus.led   = led_q;
  assign bus.busy  = busy_q;
  assign bus.level = level_q;
  assign bus.win   = win_q;
  assign bus.lose  = lose_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: reset, playback timing, round growth,
// wrong press, restart, idle waiting (or timeout) and a short game to WIN.
module tb_pattern_sequencer;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rnd   = 4'b0000;
  logic [3:0] btn   = 4'b0000;
  logic       sel_b = 1'b0;

  int errors = 0;
  int checks = 0;

  pattern_sequencer_if if_a ();
  pattern_sequencer_if if_b ();

  assign if_a.start = start;
  assign if_a.rnd   = rnd;
  assign if_a.btn   = btn;
  assign if_b.start = start;
  assign if_b.rnd   = rnd;
  assign if_b.btn   = btn;

  pattern_sequencer #(
    .MAX_LEN(16), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(if_a)
  );

  pattern_sequencer #(
    .MAX_LEN(2), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYC(8)
  ) dut_win (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_led, input logic e_busy,
                         input logic [6:0] e_level, input logic e_win, input logic e_lose);
    logic [3:0] o_led;
    logic       o_busy;
    logic [6:0] o_level;
    logic       o_win;
    logic       o_lose;
    o_led   = sel_b ? if_b.led   : if_a.led;
    o_busy  = sel_b ? if_b.busy  : if_a.busy;
    o_level = sel_b ? if_b.level : if_a.level;
    o_win   = sel_b ? if_b.win   : if_a.win;
    o_lose  = sel_b ? if_b.lose  : if_a.lose;
    chk({tag, ".led"},   {4'b0, o_led},   {4'b0, e_led});
    chk({tag, ".busy"},  {7'b0, o_busy},  {7'b0, e_busy});
    chk({tag, ".level"}, {1'b0, o_level}, {1'b0, e_level});
    chk({tag, ".win"},   {7'b0, o_win},   {7'b0, e_win});
    chk({tag, ".lose"},  {7'b0, o_lose},  {7'b0, e_lose});
    $display("step %s: led=%b busy=%b level=%0d win=%b lose=%b", tag, o_led, o_busy, o_level, o_win, o_lose);
  endtask

  // One symbol of playback: 4 lit cycles then 2 dark busy cycles.
  task automatic expect_show(input string tag, input logic [3:0] e_led, input logic [6:0] e_level);
    repeat (4) begin
      tick();
      chk_out({tag, "_on"}, e_led, 1'b1, e_level, 1'b0, 1'b0);
    end
    repeat (2) begin
      tick();
      chk_out({tag, "_gap"}, 4'b0000, 1'b1, e_level, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk_out("reset", 4'b0000, 1'b0, 7'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 1'b0, 7'd0, 1'b0, 1'b0);

    // T1: async reset in the middle of SHOW_ON
    start = 1'b1; rnd = 4'b0011;
    tick();
    start = 1'b0;
    chk_out("t1_cap", 4'b0000, 1'b1, 7'd1, 1'b0, 1'b0);
    tick(); tick();
    chk_out("t1_show", 4'b1000, 1'b1, 7'd1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_out("t1_async", 4'b0000, 1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    chk_out("t1_held", 4'b0000, 1'b0, 7'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("t1_idle", 4'b0000, 1'b0, 7'd0, 1'b0, 1'b0);

    // T2: first round, symbol 2
    start = 1'b1; rnd = 4'b0110;
    tick();
    start = 1'b0;
    chk_out("t2_cap", 4'b0000, 1'b1, 7'd1, 1'b0, 1'b0);
    expect_show("t2_p0", 4'b0100, 7'd1);
    tick();
    chk_out("t2_wait", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t2_start_ign", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b0);

    // T3: correct press grows to level 2 (new symbol 1), then level 3 (symbol 0)
    rnd = 4'b1001; btn = 4'b0100;
    tick();
    btn = 4'b0000;
    chk_out("t3_cap", 4'b0000, 1'b1, 7'd2, 1'b0, 1'b0);
    btn = 4'b0001; start = 1'b1;   // noise during playback must be ignored
    expect_show("t3_p0", 4'b0100, 7'd2);
    expect_show("t3_p1", 4'b0010, 7'd2);
    btn = 4'b0000; start = 1'b0;
    tick();
    chk_out("t3_wait", 4'b0000, 1'b0, 7'd2, 1'b0, 1'b0);
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    chk_out("t3_m0", 4'b0000, 1'b0, 7'd2, 1'b0, 1'b0);
    rnd = 4'b1100; btn = 4'b0010;
    tick();
    btn = 4'b0000;
    chk_out("t3_lvl3", 4'b0000, 1'b1, 7'd3, 1'b0, 1'b0);
    expect_show("t3_q0", 4'b0100, 7'd3);
    expect_show("t3_q1", 4'b0010, 7'd3);
    expect_show("t3_q2", 4'b0001, 7'd3);
    tick();
    chk_out("t3_wait3", 4'b0000, 1'b0, 7'd3, 1'b0, 1'b0);

    // T4: multi-bit press against expected 0001 loses, then restart
    btn = 4'b0100; tick(); btn = 4'b0000;
    chk_out("t4_m0", 4'b0000, 1'b0, 7'd3, 1'b0, 1'b0);
    btn = 4'b0010; tick(); btn = 4'b0000;
    chk_out("t4_m1", 4'b0000, 1'b0, 7'd3, 1'b0, 1'b0);
    btn = 4'b0011; tick(); btn = 4'b0000;
    chk_out("t4_lose", 4'b0000, 1'b0, 7'd3, 1'b0, 1'b1);
    btn = 4'b0001; tick(); btn = 4'b0000;
    chk_out("t4_hold", 4'b0000, 1'b0, 7'd3, 1'b0, 1'b1);
    rnd = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t4_restart", 4'b0000, 1'b1, 7'd1, 1'b0, 1'b0);
    expect_show("t4_p0", 4'b0010, 7'd1);
    tick();
    chk_out("t4_wait", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b0);

    // T6: idle behaviour in WAIT_INPUT
`ifdef PATTERN_TIMEOUT_EN
    repeat (7) tick();
    chk_out("t6_pre", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b0);
    tick();
    chk_out("t6_timeout", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b1);
`else
    repeat (1000) tick();
    chk_out("t6_idle", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b0);
    btn = 4'b0010; tick(); btn = 4'b0000;
    chk_out("t6_press", 4'b0000, 1'b1, 7'd2, 1'b0, 1'b0);
`endif

    // T5: MAX_LEN=2 instance played to WIN
    reset = 1'b0;
    tick();
    reset = 1'b1; sel_b = 1'b1; start = 1'b0; btn = 4'b0000; rnd = 4'b0000;
    tick();
    chk_out("t5_idle", 4'b0000, 1'b0, 7'd0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t5_cap1", 4'b0000, 1'b1, 7'd1, 1'b0, 1'b0);
    expect_show("t5_r1", 4'b0001, 7'd1);
    tick();
    chk_out("t5_wait1", 4'b0000, 1'b0, 7'd1, 1'b0, 1'b0);
    rnd = 4'b0111; btn = 4'b0001;
    tick();
    btn = 4'b0000;
    chk_out("t5_cap2", 4'b0000, 1'b1, 7'd2, 1'b0, 1'b0);
    expect_show("t5_r2a", 4'b0001, 7'd2);
    expect_show("t5_r2b", 4'b1000, 7'd2);
    tick();
    chk_out("t5_wait2", 4'b0000, 1'b0, 7'd2, 1'b0, 1'b0);
    btn = 4'b0001; tick(); btn = 4'b0000;
    chk_out("t5_m0", 4'b0000, 1'b0, 7'd2, 1'b0, 1'b0);
    btn = 4'b1000; tick(); btn = 4'b0000;
    chk_out("t5_win", 4'b1111, 1'b0, 7'd2, 1'b1, 1'b0);
    tick();
    chk_out("t5_win_hold", 4'b1111, 1'b0, 7'd2, 1'b1, 1'b0);
    rnd = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t5_restart", 4'b0000, 1'b1, 7'd1, 1'b0, 1'b0);
    tick();
    chk_out("t5_restart_show", 4'b0100, 1'b1, 7'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
